// File: rtl/hmmm_mem_responder.sv
// Unified 256x15 instruction/data memory for the HMMM core, with a byte-stream
// program loader that holds the core in reset until the final frame commits.
module hmmm_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned WORD_WIDTH = 15
) (
  input  logic                  ph1,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] Adr,
  input  logic                  MemWrite,
  output logic [WORD_WIDTH-9:0] MemData1,
  output logic [7:0]            MemData2_out,
  output logic                  MemData2_oe,
  input  logic [7:0]            MemData2_in,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_data,
  output logic                  ld_ready,
  output logic                  cpu_reset
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned HiW   = WORD_WIDTH - 8;

  typedef enum logic [2:0] {
    StLoadAddr,
    StLoadHi,
    StLoadLo,
    StCommit,
    StRun
  } state_e;

  state_e                state_q;
  logic                  ld_ready_q;
  logic                  cpu_reset_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [HiW-1:0]        hi_q;
  logic [7:0]            lo_q;
  logic                  last_q;
  logic                  hs;

  logic [WORD_WIDTH-1:0] mem [Depth];
  logic [WORD_WIDTH-1:0] rd_word;
  logic                  run;

  assign hs        = ld_valid & ld_ready_q;
  assign ld_ready  = ld_ready_q;
  assign cpu_reset = cpu_reset_q;

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_q     <= StLoadAddr;
      ld_ready_q  <= 1'b1;
      cpu_reset_q <= 1'b1;
      addr_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      last_q      <= 1'b0;
    end else begin
      case (state_q)
        StLoadAddr: begin
          if (hs) begin
            addr_q  <= ADDR_WIDTH'(ld_data);
            state_q <= StLoadHi;
          end
        end
        StLoadHi: begin
          if (hs) begin
            last_q  <= ld_data[7];
            hi_q    <= ld_data[HiW-1:0];
            state_q <= StLoadLo;
          end
        end
        StLoadLo: begin
          if (hs) begin
            lo_q       <= ld_data;
            ld_ready_q <= 1'b0;
            state_q    <= StCommit;
          end
        end
        StCommit: begin
          // Memory write for the frame happens on this edge (see array block).
          if (last_q) begin
            cpu_reset_q <= 1'b0;
            state_q     <= StRun;
          end else begin
            ld_ready_q <= 1'b1;
            state_q    <= StLoadAddr;
          end
        end
        StRun: begin
          state_q <= StRun;
        end
        default: begin
          ld_ready_q <= 1'b1;
          state_q    <= StLoadAddr;
        end
      endcase
    end
  end

  // Array is deliberately not reset so a reload can patch a subset of words.
  always_ff @(posedge ph1) begin
    if (state_q == StCommit) begin
      mem[addr_q] <= {hi_q, lo_q};
    end else if ((state_q == StRun) && MemWrite) begin
      mem[Adr][7:0] <= MemData2_in;
    end
  end

  assign run     = (state_q == StRun);
  assign rd_word = mem[Adr];

  always_comb begin
    MemData1     = '0;
    MemData2_out = '0;
    MemData2_oe  = 1'b0;
    if (run) begin
      MemData1     = rd_word[WORD_WIDTH-1:8];
      MemData2_out = rd_word[7:0];
      MemData2_oe  = ~MemWrite;
    end
  end

endmodule
